// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its command sequencer.
// Holds the ctrl encoding used by usr and the sequencer FSM state type.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/usr_seq_cnt.sv
// Loadable SW-bit down-counter for the remaining shift count.
// Stops at zero; is_one marks the last shift cycle.
module usr_seq_cnt #(
  parameter int SW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [SW-1:0] ld_val,
  output logic [SW-1:0] cnt,
  output logic          is_one
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     cnt <= '0;
    else if (load)                  cnt <= ld_val;
    else if (en && (cnt != '0))     cnt <= cnt - 1'b1;
  end

  assign is_one = (cnt == SW'(1));

endmodule

// File: rtl/usr_shift_seq.sv
// Command sequencer driving usr ctrl/d: one load cycle, shamt shift cycles, one done cycle.
// Define USR_SEQ_B2B_EN to accept the next command in DONE (no idle bubble).
module usr_shift_seq
  import usr_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [SW-1:0] in_shamt,
  input  logic          hold,
  output logic [1:0]    usr_ctrl,
  output logic [N-1:0]  usr_d,
  output logic          busy,
  output logic          done
);

  seq_state_e    state, nstate;
  logic [N-1:0]  data_q;
  logic          dir_q;
  logic [SW-1:0] shamt_sat;
  logic [SW-1:0] cnt;
  logic          cnt_one;
  logic          accept;
  logic          cnt_en;

`ifdef USR_SEQ_B2B_EN
  assign in_ready = (state == ST_IDLE) || (state == ST_DONE);
`else
  assign in_ready = (state == ST_IDLE);
`endif

  assign accept    = in_valid && in_ready;
  assign shamt_sat = (in_shamt > SW'(N)) ? SW'(N) : in_shamt;
  assign cnt_en    = (state == ST_SHIFT) && !hold;
  assign busy      = (state != ST_IDLE);
  assign usr_d     = data_q;

  usr_seq_cnt #(.SW(SW)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .en     (cnt_en),
    .ld_val (shamt_sat),
    .cnt    (cnt),
    .is_one (cnt_one)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      data_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        data_q <= in_data;
        dir_q  <= in_dir;
      end
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (accept) nstate = ST_LOAD;
      ST_LOAD:  nstate = (cnt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (!hold && cnt_one) nstate = ST_DONE;
      // accept can only be true here when back-to-back mode opens in_ready
      ST_DONE:  nstate = accept ? ST_LOAD : ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    usr_ctrl = USR_HOLD;
    done     = 1'b0;
    case (state)
      ST_LOAD:  usr_ctrl = USR_LOAD;
      ST_SHIFT: usr_ctrl = hold ? USR_HOLD : (dir_q ? USR_SHL : USR_SHR);
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_seq.sv
// Self-checking bench for usr_shift_seq with a behavioural usr model on its outputs.
// Table of commands plus hand sequences for mid-command reset and back-to-back issue.
module tb_usr_shift_seq;
  import usr_pkg::*;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          in_dir = 1'b0;
  logic [SW-1:0] in_shamt = '0;
  logic          hold = 1'b0;
  logic [1:0]    usr_ctrl;
  logic [N-1:0]  usr_d;
  logic          busy;
  logic          done;

  usr_shift_seq #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_shamt (in_shamt),
    .hold     (hold),
    .usr_ctrl (usr_ctrl),
    .usr_d    (usr_d),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // downstream usr model, zero fill on both shift directions
  logic [N-1:0] mq = '0;
  always @(posedge clock) begin
    case (usr_ctrl)
      USR_LOAD: mq <= usr_d;
      USR_SHR:  mq <= mq >> 1;
      USR_SHL:  mq <= mq << 1;
      default:  ;
    endcase
  end

  int ntests = 0;
  int nfail  = 0;
  logic [N-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name);
    logic [N-1:0] e;
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " q"}, 32'(mq), 32'(e));
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        dir;
    logic [3:0]  shamt;
    logic [31:0] hmask;
    logic [7:0]  exp_q;
    int          exp_len;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int rem;
    int st;     // 1 load, 2 shift, 3 done
    bit fin;
    logic [1:0] ectrl;
    logic       edone;
    rem = (v.shamt > 4'd8) ? 8 : int'(v.shamt);
    @(negedge clock);
    chk({name, " ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = v.data; in_dir = v.dir; in_shamt = v.shamt;
    sb.push_back(v.exp_q);
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = 8'($urandom); in_dir = 1'($urandom); in_shamt = 4'($urandom);
    st = 1; fin = 0;
    for (int k = 0; k < 32 && !fin; k++) begin
      hold = v.hmask[k];
      @(negedge clock);
      edone = 1'b0;
      ectrl = USR_HOLD;
      case (st)
        1: begin
          ectrl = USR_LOAD;
          chk({name, " usr_d"}, 32'(usr_d), 32'(v.data));
          st = (rem > 0) ? 2 : 3;
        end
        2: begin
          if (!hold) begin
            ectrl = v.dir ? USR_SHL : USR_SHR;
            rem--;
            if (rem == 0) st = 3;
          end
        end
        default: begin
          edone = 1'b1;
          fin = 1;
          chk({name, " len"}, 32'(k + 1), 32'(v.exp_len));
        end
      endcase
      chk({name, " ctrl"}, 32'(usr_ctrl), 32'(ectrl));
      chk({name, " done"}, 32'(done), 32'(edone));
      chk({name, " busy"}, 32'(busy), 32'd1);
      if (edone) chk_q(name);
      @(posedge clock); #1;
    end
    hold = 1'b0;
    @(negedge clock);
    chk({name, " idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[7];

`ifdef USR_SEQ_B2B_EN
  localparam int BL = 7;
  logic [1:0] b2b_ctrl[BL] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00};
  logic       b2b_done[BL] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  localparam int BL = 8;
  logic [1:0] b2b_ctrl[BL] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00};
  logic       b2b_done[BL] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    vt[0] = '{8'hDB, 1'b0, 4'd1,  32'h0,  8'h6D, 3};
    vt[1] = '{8'hAA, 1'b1, 4'd3,  32'h4,  8'h50, 6};
    vt[2] = '{8'hF0, 1'b0, 4'd0,  32'h0,  8'hF0, 2};
    vt[3] = '{8'h81, 1'b0, 4'd12, 32'h0,  8'h00, 10};
    vt[4] = '{8'h80, 1'b0, 4'd7,  32'h19, 8'h01, 11};
    vt[5] = '{8'h3C, 1'b1, 4'd4,  32'h20, 8'hC0, 6};
    vt[6] = '{8'h01, 1'b1, 4'd7,  32'h0,  8'h80, 9};

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst ctrl",     32'(usr_ctrl), 32'd0);
    chk("rst usr_d",    32'(usr_d),    32'd0);
    chk("rst busy",     32'(busy),     32'd0);
    chk("rst done",     32'(done),     32'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // reset mid-command after two of five shifts
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0; in_shamt = 4'd5;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("abort q2", 32'(mq), 32'h3F);
    chk("abort pre busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort ctrl",  32'(usr_ctrl), 32'd0);
    chk("abort usr_d", 32'(usr_d),    32'd0);
    chk("abort busy",  32'(busy),     32'd0);
    chk("abort ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("abort done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("post abort done", 32'(done), 32'd0);
      chk("post abort ctrl", 32'(usr_ctrl), 32'd0);
    end
    run_vec(vt[0], "restart");

    // two commands presented back to back with in_valid held high
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h11; in_dir = 1'b0; in_shamt = 4'd1;
    sb.push_back(8'h08);
    @(posedge clock); #1;
    in_data = 8'h22; in_dir = 1'b1; in_shamt = 4'd2;
    sb.push_back(8'h88);
    for (int c = 0; c < BL; c++) begin
      logic acc;
      @(negedge clock);
      acc = in_ready && in_valid;
      chk($sformatf("b2b ctrl%0d", c), 32'(usr_ctrl), 32'(b2b_ctrl[c]));
      chk($sformatf("b2b done%0d", c), 32'(done), 32'(b2b_done[c]));
      if (done) chk_q("b2b");
      @(posedge clock); #1;
      if (acc) in_valid = 1'b0;
    end
    @(negedge clock);
    chk("b2b idle", 32'(busy), 32'd0);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
